// File: rtl/coproc_cmd_sequencer_if.sv
// coproc_cmd_sequencer_if: CPU command/status and coprocessor handshake signals
interface coproc_cmd_sequencer_if #(
  parameter int DEPTH = 4
) ();
  logic [7:0]                   CTL_IN;
  logic                         CP_DONE;
  logic                         CP_START;
  logic [7:0]                   CP_CMD;
  logic [1:0]                   STS;
  logic [$clog2(DEPTH+1)-1:0]   LEVEL;
  modport master (output CTL_IN, CP_DONE, input CP_START, CP_CMD, STS, LEVEL);
  modport slave  (input CTL_IN, CP_DONE, output CP_START, CP_CMD, STS, LEVEL);
endinterface

// File: rtl/coproc_cmd_sequencer.sv
// coproc_cmd_sequencer: buffers CPU command pulses and issues them to the coprocessor with a watchdog
module coproc_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1048575,
  parameter int TO_W    = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  coproc_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            err_q, err_d;
  logic            abort, clr, push, push_ok, pop, tout, full;
  // Decode the command byte and sequence one command at a time through the coprocessor.
  always_comb begin
    abort   = bus.CTL_IN == 8'hFF;
    clr     = bus.CTL_IN == 8'hFE;
    push    = bus.CTL_IN != 8'h00 && !abort && !clr;
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    tout    = 1'b0;
    case (state_q)
      IDLE: begin
        pop     = level_q != '0 && !abort;
        state_d = pop ? ISSUE : IDLE;
      end
      ISSUE: begin
        cnt_d   = TO_W'(1);
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + TO_W'(1);
        tout    = !abort && !bus.CP_DONE && cnt_q == TO_W'(TIMEOUT);
        state_d = (abort || bus.CP_DONE || tout) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    full    = level_q == LW'(DEPTH);
    push_ok = push && (!full || pop);
    level_d = abort ? '0 : level_q + LW'(push_ok) - LW'(pop);
    wr_d    = abort ? '0 : wr_q + AW'(push_ok);
    rd_d    = abort ? '0 : rd_q + AW'(pop);
    cmd_d   = pop ? mem_q[rd_q] : cmd_q;
    err_d   = (push && !push_ok) || tout || (err_q && !clr);
  end
  // Control and status registers, cleared asynchronously so a reset drops any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end
  // Command storage; contents are meaningless outside the occupied window so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= bus.CTL_IN;
  end
  assign bus.CP_START = state_q == ISSUE;
  assign bus.CP_CMD   = cmd_q;
  assign bus.STS      = {err_q, state_q != IDLE || level_q != '0};
  assign bus.LEVEL    = level_q;
endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// tb_coproc_cmd_sequencer: directed and random stimulus checked against a queue-based reference model
module tb_coproc_cmd_sequencer;
  localparam int DEPTH = 4, TIMEOUT = 16, TO_W = 5;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  coproc_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();
  coproc_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int total = 0, bad = 0;
  logic [7:0] m_q [$];
  int         m_age;
  logic [7:0] m_cmd;
  logic       m_err;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_q.delete();
    m_age = -1;
    m_cmd = 8'h00;
    m_err = 1'b0;
  endtask
  task automatic m_step(input logic [7:0] c, input logic d);
    logic ovf, tout;
    ovf = 1'b0;
    tout = 1'b0;
    if (c == 8'hFF) begin
      m_q.delete();
      m_age = -1;
    end else begin
      if (m_age < 0) begin
        if (m_q.size() > 0) begin
          m_cmd = m_q.pop_front();
          m_age = 0;
        end
      end else if (m_age == 0) m_age = 1;
      else if (d) m_age = -1;
      else if (m_age == TIMEOUT) begin
        tout = 1'b1;
        m_age = -1;
      end else m_age++;
      if (c != 8'h00 && c != 8'hFE) begin
        if (m_q.size() < DEPTH) m_q.push_back(c);
        else ovf = 1'b1;
      end
    end
    m_err = (ovf || tout) ? 1'b1 : (c == 8'hFE) ? 1'b0 : m_err;
  endtask
  task automatic compare();
    check("start", bus.CP_START, m_age == 0);
    check("cmd", bus.CP_CMD, m_cmd);
    check("level", bus.LEVEL, m_q.size());
    check("sts", bus.STS, {m_err, (m_age >= 0) || (m_q.size() != 0)});
  endtask
  task automatic step(input logic [7:0] c, input logic d);
    @(negedge clk);
    bus.CTL_IN = c;
    bus.CP_DONE = d;
    @(posedge clk);
    m_step(c, d);
    #1 compare();
  endtask
  task automatic do_reset();
    bus.CTL_IN = 8'h00;
    bus.CP_DONE = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_start", bus.CP_START, 0);
    check("rst_cmd", bus.CP_CMD, 0);
    check("rst_sts", bus.STS, 0);
    check("rst_level", bus.LEVEL, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] c;
    int r;
    bus.CTL_IN = 8'h00;
    bus.CP_DONE = 1'b0;
    #2 do_reset();
    step(8'h03, 0);
    check("single_busy", bus.STS, 2'b01);
    step(8'h00, 0);
    check("single_start", bus.CP_START, 1);
    check("single_cmd", bus.CP_CMD, 8'h03);
    for (int i = 3; i <= 10; i++) step(8'h00, 0);
    step(8'h00, 1);
    check("single_idle", bus.STS, 2'b00);
    step(8'h11, 0);
    step(8'h22, 0);
    step(8'h33, 0);
    check("queue_level", bus.LEVEL, 2);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 6; i++) step(8'h00, 0);
      step(8'h00, 1);
    end
    for (int i = 0; i < 6; i++) step(8'h00, 0);
    step(8'h00, 1);
    for (int i = 0; i < 6; i++) step(8'hA0 + 8'(i), 0);
    check("ovf_err", bus.STS[1], 1);
    check("ovf_level", bus.LEVEL, 4);
    step(8'hFE, 0);
    check("clr_err", bus.STS[1], 0);
    check("clr_level", bus.LEVEL, 4);
    do_reset();
    step(8'h05, 0);
    step(8'h06, 0);
    for (int i = 3; i <= 19; i++) step(8'h00, 0);
    check("to_err", bus.STS[1], 1);
    step(8'h00, 0);
    check("to_next_start", bus.CP_START, 1);
    check("to_next_cmd", bus.CP_CMD, 8'h06);
    do_reset();
    step(8'h07, 0);
    step(8'h00, 0);
    for (int i = 3; i <= 18; i++) step(8'h00, 0);
    step(8'h00, 1);
    check("done16_sts", bus.STS, 2'b00);
    do_reset();
    for (int i = 0; i < 4; i++) step(8'h40 + 8'(i), 0);
    step(8'h00, 0);
    check("abort_pre_level", bus.LEVEL, 3);
    step(8'hFF, 0);
    check("abort_level", bus.LEVEL, 0);
    check("abort_sts", bus.STS, 2'b00);
    for (int i = 0; i < 4; i++) step(8'h00, 1);
    for (int i = 0; i < 4; i++) step(8'h50 + 8'(i), 0);
    step(8'h00, 0);
    do_reset();
    step(8'h09, 0);
    step(8'h00, 0);
    check("rst_rel_start", bus.CP_START, 1);
    check("rst_rel_cmd", bus.CP_CMD, 8'h09);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 55) ? 8'h00 : (r < 90) ? 8'($urandom_range(1, 253)) : (r < 95) ? 8'hFE : 8'hFF;
      step(c, $urandom_range(0, 7) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
